// File: rtl/mem_bist_pkg.sv
// mem_bist_pkg: phase encoding, request field map and data pattern.
// MEM_BIST_MISALIGN_EN enables the misaligned read pass phases.
package mem_bist_pkg;

    typedef enum logic [2:0] {
        PH_IDLE    = 3'd0,
        PH_WRITE   = 3'd1,
        PH_WDRAIN  = 3'd2,
        PH_READ    = 3'd3,
        PH_RDRAIN  = 3'd4,
        PH_DONE    = 3'd5,
        PH_MREAD   = 3'd6,
        PH_MRDRAIN = 3'd7
    } phase_e;

    localparam int RQ_W           = 65;
    localparam int RQ_ADDR_MSB    = 64;
    localparam int RQ_ADDR_LSB    = 33;
    localparam int RQ_ISWRITE_BIT = 32;
    localparam int RQ_DATA_MSB    = 31;

    function automatic logic [31:0] pat(
        input logic [31:0] addr,
        input logic [31:0] seed
    );
        return addr ^ seed;
    endfunction

endpackage

// File: rtl/mem_bist_checker.sv
// mem_bist_checker: read-response compare, error count, first-fail capture.
// MEM_BIST_MISALIGN_EN adds the byte-offset window expectation.
module mem_bist_checker
    import mem_bist_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          LGNW      = 8,
    parameter logic [31:0] SEED      = 32'hA5A5_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr_i,
    input  logic            restart_i,
    input  logic            mis_i,
    input  logic            chk_i,
    input  logic [31:0]     data_i,
    output logic [LGNW:0]   checked_o,
    output logic [15:0]     err_count_o,
    output logic [31:0]     first_fail_addr_o
);

    logic [LGNW:0] checked_q, checked_d;
    logic [15:0]   err_q, err_d;
    logic [31:0]   ffa_q, ffa_d;
    logic [31:0]   word_addr;
    logic [31:0]   exp_addr;
    logic [31:0]   exp_data;
    logic          miss;

`ifdef MEM_BIST_MISALIGN_EN
    logic [31:0] pat_lo;
    logic [31:0] pat_hi;
`else
    logic        unused_mis;
    assign unused_mis = mis_i;
`endif

    // Expected address and data for the next in-order read response
    always_comb begin
        word_addr = BASE_ADDR + (32'(checked_q) << 2);
        exp_addr  = word_addr;
        exp_data  = pat(word_addr, SEED);
`ifdef MEM_BIST_MISALIGN_EN
        pat_lo = pat(word_addr, SEED);
        pat_hi = pat(word_addr + 32'd4, SEED);
        if (mis_i) begin
            exp_addr = word_addr + 32'd1;
            exp_data = {pat_hi[7:0], pat_lo[31:8]};
        end
`endif
        miss = (exp_data != data_i);
    end

    // Counter, saturating error count and first-fail capture updates
    always_comb begin
        checked_d = checked_q;
        err_d     = err_q;
        ffa_d     = ffa_q;
        if (clr_i) begin
            checked_d = '0;
            err_d     = '0;
            ffa_d     = '0;
        end else begin
            if (restart_i) begin
                checked_d = '0;
            end
            if (chk_i) begin
                checked_d = checked_q + 1'b1;
                if (miss) begin
                    if (err_q != 16'hFFFF) begin
                        err_d = err_q + 16'd1;
                    end
                    if (err_q == 16'd0) begin
                        ffa_d = exp_addr;
                    end
                end
            end
        end
    end

    // Checker state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            checked_q <= '0;
            err_q     <= '0;
            ffa_q     <= '0;
        end else begin
            checked_q <= checked_d;
            err_q     <= err_d;
            ffa_q     <= ffa_d;
        end
    end

    assign checked_o         = checked_q;
    assign err_count_o       = err_q;
    assign first_fail_addr_o = ffa_q;

endmodule

// File: rtl/mem_bist_master.sv
// mem_bist_master: write-then-read/compare BIST initiator on get/put ports.
// MEM_BIST_MISALIGN_EN adds a misaligned read pass before DONE.
module mem_bist_master
    import mem_bist_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
    parameter int          LGNW            = 8,
    parameter logic [31:0] SEED            = 32'hA5A5_0000,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            start,
    output logic [RQ_W-1:0] obtain_rq_get,
    output logic            RDY_obtain_rq_get,
    input  logic            EN_obtain_rq_get,
    input  logic [31:0]     send_rs_put,
    input  logic            EN_send_rs_put,
    output logic            RDY_send_rs_put,
    output logic            done,
    output logic            pass,
    output logic [15:0]     err_count,
    output logic [31:0]     first_fail_addr,
    output logic            proto_err
);

    localparam int unsigned   NW_I    = 1 << LGNW;
    localparam logic [LGNW:0] NW      = NW_I[LGNW:0];
    localparam logic [2:0]    MAX_OUT = 3'(MAX_OUTSTANDING);

    phase_e        phase_q, phase_d;
    logic [LGNW:0] issued_q, issued_d;
    logic [2:0]    out_q, out_d;
    logic          done_q, done_d;
    logic          pass_q, pass_d;
    logic          proto_q, proto_d;
    logic          rs_rdy_q, rs_rdy_d;

    logic          mis_phase;
    logic          issue_phase;
    logic [LGNW:0] issue_lim;
    logic          rq_rdy;
    logic          xfer;
    logic          rsp_ok;
    logic          rsp_bad;
    logic          chk;
    logic          clr;
    logic          restart;
    logic [31:0]   rq_addr;
    logic          rq_wr;
    logic [31:0]   rq_data;
    logic [LGNW:0] checked;
    logic [15:0]   err_w;
    logic [31:0]   ffa_w;

`ifdef MEM_BIST_MISALIGN_EN
    assign mis_phase = (phase_q == PH_MREAD) || (phase_q == PH_MRDRAIN);
    assign issue_lim = (phase_q == PH_MREAD) ? NW - 1'b1 : NW;
    assign issue_phase = (phase_q == PH_WRITE) || (phase_q == PH_READ) ||
                         (phase_q == PH_MREAD);
`else
    assign mis_phase = 1'b0;
    assign issue_lim = NW;
    assign issue_phase = (phase_q == PH_WRITE) || (phase_q == PH_READ);
`endif

    assign rq_rdy  = issue_phase && (issued_q < issue_lim) && (out_q < MAX_OUT);
    assign xfer    = rq_rdy && EN_obtain_rq_get;
    assign rsp_ok  = EN_send_rs_put && (out_q != 3'd0);
    assign rsp_bad = EN_send_rs_put && (out_q == 3'd0);
    assign chk     = rsp_ok && ((phase_q == PH_READ) ||
                                (phase_q == PH_RDRAIN) || mis_phase);

    // Request word built from registered state only; zero when not offered
    always_comb begin
        rq_addr = BASE_ADDR + (32'(issued_q) << 2);
        if (mis_phase) begin
            rq_addr = rq_addr + 32'd1;
        end
        rq_wr   = (phase_q == PH_WRITE);
        rq_data = rq_wr ? pat(rq_addr, SEED) : 32'h0;
        obtain_rq_get = '0;
        if (rq_rdy) begin
            obtain_rq_get[RQ_ADDR_MSB:RQ_ADDR_LSB] = rq_addr;
            obtain_rq_get[RQ_ISWRITE_BIT]          = rq_wr;
            obtain_rq_get[RQ_DATA_MSB:0]           = rq_data;
        end
    end

    // Phase sequencing, issue/outstanding counters and result flags
    always_comb begin
        phase_d  = phase_q;
        issued_d = issued_q;
        out_d    = out_q;
        done_d   = done_q;
        pass_d   = pass_q;
        proto_d  = proto_q;
        rs_rdy_d = 1'b1;
        clr      = 1'b0;
        restart  = 1'b0;
        if (xfer && !rsp_ok) begin
            out_d = out_q + 3'd1;
        end else if (!xfer && rsp_ok) begin
            out_d = out_q - 3'd1;
        end
        if (xfer) begin
            issued_d = issued_q + 1'b1;
        end
        if (rsp_bad && (phase_q != PH_IDLE)) begin
            proto_d = 1'b1;
        end
        unique case (phase_q)
            PH_IDLE, PH_DONE: begin
                if (start) begin
                    phase_d  = PH_WRITE;
                    issued_d = '0;
                    done_d   = 1'b0;
                    pass_d   = 1'b0;
                    proto_d  = 1'b0;
                    clr      = 1'b1;
                end
            end
            PH_WRITE: begin
                if (issued_q == NW) begin
                    phase_d = PH_WDRAIN;
                end
            end
            PH_WDRAIN: begin
                if (out_q == 3'd0) begin
                    phase_d  = PH_READ;
                    issued_d = '0;
                end
            end
            PH_READ: begin
                if (issued_q == NW) begin
                    phase_d = PH_RDRAIN;
                end
            end
            PH_RDRAIN: begin
                if ((out_q == 3'd0) && (checked == NW)) begin
`ifdef MEM_BIST_MISALIGN_EN
                    phase_d  = PH_MREAD;
                    issued_d = '0;
                    restart  = 1'b1;
`else
                    phase_d = PH_DONE;
                    done_d  = 1'b1;
                    pass_d  = (err_w == 16'd0) && !proto_d;
`endif
                end
            end
`ifdef MEM_BIST_MISALIGN_EN
            PH_MREAD: begin
                if (issued_q == NW - 1'b1) begin
                    phase_d = PH_MRDRAIN;
                end
            end
            PH_MRDRAIN: begin
                if ((out_q == 3'd0) && (checked == NW - 1'b1)) begin
                    phase_d = PH_DONE;
                    done_d  = 1'b1;
                    pass_d  = (err_w == 16'd0) && !proto_d;
                end
            end
`endif
            default: begin
            end
        endcase
    end

    // Control state registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            phase_q  <= PH_IDLE;
            issued_q <= '0;
            out_q    <= '0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            proto_q  <= 1'b0;
            rs_rdy_q <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            issued_q <= issued_d;
            out_q    <= out_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
            proto_q  <= proto_d;
            rs_rdy_q <= rs_rdy_d;
        end
    end

    mem_bist_checker #(
        .BASE_ADDR (BASE_ADDR),
        .LGNW      (LGNW),
        .SEED      (SEED)
    ) u_checker (
        .clk               (CLK),
        .rst_n             (RST_N),
        .clr_i             (clr),
        .restart_i         (restart),
        .mis_i             (mis_phase),
        .chk_i             (chk),
        .data_i            (send_rs_put),
        .checked_o         (checked),
        .err_count_o       (err_w),
        .first_fail_addr_o (ffa_w)
    );

    assign RDY_obtain_rq_get = rq_rdy;
    assign RDY_send_rs_put   = rs_rdy_q;
    assign done              = done_q;
    assign pass              = pass_q;
    assign proto_err         = proto_q;
    assign err_count         = err_w;
    assign first_fail_addr   = ffa_w;

endmodule
